seq_counter_param: RTL and testbench
====================================

// Module: seq_counter_param
// PURPOSE
//  Programmable sequence counter. Steps an index through a DEPTH-entry table and
//  outputs the WIDTH-bit entry at the current index. Repeated values are allowed
//  because state is the index, not the value. Supports table rewrite, length,
//  direction, load and wrap counting. Drives sequenced stimulus/pattern outputs.
// PARAMETERS
//  WIDTH   4  bits per table entry / Q width
//  DEPTH   5  table entries (>=2); IW = $clog2(DEPTH), LW = $clog2(DEPTH+1)
//  WRAP_W  8  width of wrap-event counter
// PORTS
//  CLK       in   1       clock, all state on rising edge
//  RESET     in   1       synchronous, active-high reset
//  EN        in   1       advance one step this cycle
//  DIR       in   1       0 = forward (idx+1), 1 = backward (idx-1)
//  LOAD      in   1       force index to LOAD_IDX
//  LOAD_IDX  in   IW      load target (values >= eff_len clamp to eff_len-1)
//  LEN       in   LW      active length; eff_len = 0->1, >DEPTH->DEPTH, else LEN
//  WE        in   1       table write strobe
//  WADDR     in   IW      table write address (>= DEPTH ignored)
//  WDATA     in   WIDTH   table write data
//  Q         out  WIDTH   table[IDX]
//  IDX       out  IW      current index
//  TC        out  1       one-cycle pulse: the step just taken wrapped
//  WRAPS     out  WRAP_W  count of wraps, modulo 2^WRAP_W
// BEHAVIOUR
//  - One clock (CLK); reset is synchronous, active-high (RESET).
//  - Reset: IDX=0, TC=0, WRAPS=0, table[i] = (2*(i+1)) mod 2^WIDTH; Q=2 after reset.
//  - Priority per cycle: RESET > LOAD > EN. Holds when none is active.
//  - LOAD: IDX <= clamp(LOAD_IDX), WRAPS <= 0, TC <= 0. EN ignored that cycle.
//  - EN, DIR=0: if IDX >= eff_len-1 -> IDX <= 0, TC <= 1, WRAPS++; else IDX+1, TC <= 0.
//  - EN, DIR=1: if IDX==0 -> IDX <= eff_len-1, TC <= 1, WRAPS++;
//    if IDX > eff_len-1 (LEN reduced mid-run) -> IDX <= eff_len-1, TC <= 0;
//    else IDX-1, TC <= 0.
//  - TC is registered; it goes high in the same cycle as the wrapped IDX/Q, low next
//    cycle unless another wrap occurs. eff_len=1: every EN step wraps (TC held high).
//  - WRAPS rolls over at 2^WRAP_W - 1 -> 0 silently.
//  - Q is a combinational read of the registered table at registered IDX; no extra
//    latency vs IDX. Step EN at edge k -> new Q visible after edge k.
//  - Table write takes effect at the edge. A write to the current IDX shows on Q after
//    that edge. Write and step in the same cycle: write lands, Q shows
//    table[new IDX] (with the new data if WADDR == new IDX).
//  - RESET during operation restores the default table (writes are lost).
//  - LEN changes take effect immediately for the next step decision. No IDX change
//    without EN/LOAD.
// STRUCTURE
//  - Package seq_counter_pkg: function default_entry(i, WIDTH), function
//    clamp_len(LEN, DEPTH), constant DIR_FWD=0 / DIR_BWD=1.
//  - Sub-module seq_table: DEPTH x WIDTH register file, sync write, async read,
//    reset to default_entry. Top holds index FSM, TC, WRAPS.
// TESTING
//  1. Reset, EN=1, DIR=0, LEN=5 -> Q: 2,4,6,8,10,2; TC high only with Q=2 (IDX=0),
//     WRAPS=1.
//  2. Write table[3]=4, table[4]=8, then run -> Q: 2,4,6,4,8,2,... (legacy sequence),
//     WRAPS increments once per 5 steps.
//  3. DIR=1 from IDX=0, LEN=5 -> IDX 4,3,2,1,0,4; TC on first step and on 0->4.
//  4. IDX=4, set LEN=3, EN DIR=0 -> IDX=0, TC=1. Repeat from IDX=4 with DIR=1
//     -> IDX=2, TC=0.
//  5. LOAD=1, EN=1, LOAD_IDX=7, LEN=5 -> IDX=4, WRAPS=0, TC=0. LEN=0, EN -> IDX=0,
//     TC=1 every cycle.
//  6. RESET mid-run after writes, WRAPS=200 -> next cycle IDX=0, WRAPS=0, Q=2,
//     table defaults. Run WRAPS past 255 -> 0.

Source files
------------

// File: rtl/seq_counter_pkg.sv
// Shared constants and helpers for the programmable sequence counter.
package seq_counter_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    // Power-on table contents: 2, 4, 6, ... truncated to the entry width.
    function automatic int unsigned default_entry(input int unsigned i, input int unsigned width);
        int unsigned v;
        v = 32'd2 * (i + 32'd1);
        if (width < 32)
            v = v & ((32'd1 << width) - 32'd1);
        return v;
    endfunction

    // Effective sequence length: at least one entry, at most the table depth.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        if (len == 0)
            return 32'd1;
        else if (len > depth)
            return depth;
        else
            return len;
    endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous read, resets to the default pattern.
module seq_table
    import seq_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 5,
    localparam int unsigned IW = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WE,
    input  logic [IW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic [IW-1:0]    RADDR,
    output logic [WIDTH-1:0] RDATA
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Out-of-range write addresses are dropped rather than aliased.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= WIDTH'(default_entry(i, WIDTH));
        end else if (WE && (32'(WADDR) < DEPTH)) begin
            mem[WADDR] <= WDATA;
        end
    end

    assign RDATA = (32'(RADDR) < DEPTH) ? mem[RADDR] : '0;

endmodule

// File: rtl/seq_counter_param.sv
// Programmable sequence counter: steps an index through a writable table and reports wraps.
module seq_counter_param
    import seq_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 5,
    parameter int unsigned WRAP_W = 8,
    localparam int unsigned IW = $clog2(DEPTH),
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              DIR,
    input  logic              LOAD,
    input  logic [IW-1:0]     LOAD_IDX,
    input  logic [LW-1:0]     LEN,
    input  logic              WE,
    input  logic [IW-1:0]     WADDR,
    input  logic [WIDTH-1:0]  WDATA,
    output logic [WIDTH-1:0]  Q,
    output logic [IW-1:0]     IDX,
    output logic              TC,
    output logic [WRAP_W-1:0] WRAPS
);

    logic [IW-1:0]     last_idx;
    logic [IW-1:0]     load_tgt;
    logic [IW-1:0]     idx_nxt;
    logic              tc_nxt;
    logic [WRAP_W-1:0] wraps_nxt;

    assign last_idx = IW'(clamp_len(32'(LEN), DEPTH) - 32'd1);
    assign load_tgt = (LOAD_IDX > last_idx) ? last_idx : LOAD_IDX;

    // Step decision; LEN is live, so an index beyond a shortened range is pulled back in.
    always_comb begin
        idx_nxt   = IDX;
        tc_nxt    = 1'b0;
        wraps_nxt = WRAPS;
        if (LOAD) begin
            idx_nxt   = load_tgt;
            wraps_nxt = '0;
        end else if (EN) begin
            if (DIR == DIR_FWD) begin
                if (IDX >= last_idx) begin
                    idx_nxt   = '0;
                    tc_nxt    = 1'b1;
                    wraps_nxt = WRAPS + WRAP_W'(1);
                end else begin
                    idx_nxt = IDX + IW'(1);
                end
            end else begin
                if (IDX == '0) begin
                    idx_nxt   = last_idx;
                    tc_nxt    = 1'b1;
                    wraps_nxt = WRAPS + WRAP_W'(1);
                end else if (IDX > last_idx) begin
                    idx_nxt = last_idx;
                end else begin
                    idx_nxt = IDX - IW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            IDX   <= '0;
            TC    <= 1'b0;
            WRAPS <= '0;
        end else begin
            IDX   <= idx_nxt;
            TC    <= tc_nxt;
            WRAPS <= wraps_nxt;
        end
    end

    seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
        .CLK   (CLK),
        .RESET (RESET),
        .WE    (WE),
        .WADDR (WADDR),
        .WDATA (WDATA),
        .RADDR (IDX),
        .RDATA (Q)
    );

endmodule

// File: tb/tb_seq_counter_param.sv
// Directed scoreboard bench for seq_counter_param (WIDTH=4, DEPTH=5, WRAP_W=8).
module tb_seq_counter_param;

    logic       CLK = 1'b0;
    logic       RESET, EN, DIR, LOAD, WE;
    logic [2:0] LOAD_IDX, LEN, WADDR;
    logic [3:0] WDATA;
    logic [3:0] Q;
    logic [2:0] IDX;
    logic       TC;
    logic [7:0] WRAPS;

    typedef struct {
        logic [2:0]  idx;
        logic [3:0]  q;
        logic        tc;
        logic [7:0]  wraps;
        int unsigned test;
        int unsigned step;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned test_no  = 0;
    int unsigned step_no  = 0;

    seq_counter_param #(.WIDTH(4), .DEPTH(5), .WRAP_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .DIR      (DIR),
        .LOAD     (LOAD),
        .LOAD_IDX (LOAD_IDX),
        .LEN      (LEN),
        .WE       (WE),
        .WADDR    (WADDR),
        .WDATA    (WDATA),
        .Q        (Q),
        .IDX      (IDX),
        .TC       (TC),
        .WRAPS    (WRAPS)
    );

    always #5 CLK = ~CLK;

    task automatic drv(input logic en, input logic dir, input logic ld, input int lidx, input int len);
        EN = en; DIR = dir; LOAD = ld; LOAD_IDX = 3'(lidx); LEN = 3'(len); WE = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        WE = 1'b1; WADDR = 3'(a); WDATA = 4'(d);
    endtask

    // Queue the state expected after the coming edge, then advance one cycle.
    task automatic chk(input int idx, input int q, input int tc, input int w);
        exp_t e;
        e.idx = 3'(idx); e.q = 4'(q); e.tc = 1'(tc); e.wraps = 8'(w);
        e.test = test_no; e.step = step_no;
        step_no++;
        exp_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic cmp(input string f, input logic [31:0] act, input logic [31:0] req, input exp_t e);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL t%0d.s%0d %s: got %0d, expected %0d", e.test, e.step, f, act, req);
        end
    endtask

    // Monitor: one queued expectation is consumed just after the edge it belongs to.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("IDX",   32'(IDX),   32'(e.idx),   e);
                cmp("Q",     32'(Q),     32'(e.q),     e);
                cmp("TC",    32'(TC),    32'(e.tc),    e);
                cmp("WRAPS", 32'(WRAPS), 32'(e.wraps), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; WADDR = '0; WDATA = '0;
        drv(0, 0, 0, 0, 5);
        // 1: reset state, then forward run with default table
        test_no = 1; step_no = 0;
        chk(0, 2, 0, 0);
        RESET = 1'b0;
        drv(1, 0, 0, 0, 5);
        chk(1, 4, 0, 0); chk(2, 6, 0, 0); chk(3, 8, 0, 0); chk(4, 10, 0, 0);
        chk(0, 2, 1, 1);
        drv(0, 0, 0, 0, 5);
        chk(0, 2, 0, 1);

        // 2: legacy table rewrite, write-with-step, write to current index, bad address
        test_no = 2; step_no = 0;
        drv(0, 0, 0, 0, 5); wr(3, 4);
        chk(0, 2, 0, 1);
        drv(1, 0, 0, 0, 5); wr(4, 8);
        chk(1, 4, 0, 1);
        drv(1, 0, 0, 0, 5);
        chk(2, 6, 0, 1); chk(3, 4, 0, 1); chk(4, 8, 0, 1); chk(0, 2, 1, 2);
        chk(1, 4, 0, 2); chk(2, 6, 0, 2); chk(3, 4, 0, 2); chk(4, 8, 0, 2); chk(0, 2, 1, 3);
        drv(0, 0, 0, 0, 5); wr(0, 15);
        chk(0, 15, 0, 3);
        drv(1, 0, 0, 0, 5); wr(1, 9);
        chk(1, 9, 0, 3);
        drv(0, 0, 0, 0, 5); wr(6, 0);
        chk(1, 9, 0, 3);
        // table is now 15, 9, 6, 4, 8

        // 3: backward run from index 0
        test_no = 3; step_no = 0;
        drv(0, 0, 1, 0, 5);
        chk(0, 15, 0, 0);
        drv(1, 1, 0, 0, 5);
        chk(4, 8, 1, 1); chk(3, 4, 0, 1); chk(2, 6, 0, 1); chk(1, 9, 0, 1);
        chk(0, 15, 0, 1); chk(4, 8, 1, 2);

        // 4: LEN reduced while beyond the new range
        test_no = 4; step_no = 0;
        drv(1, 0, 0, 0, 3);
        chk(0, 15, 1, 3);
        drv(0, 0, 1, 4, 5);
        chk(4, 8, 0, 0);
        drv(1, 1, 0, 0, 3);
        chk(2, 6, 0, 0); chk(1, 9, 0, 0); chk(0, 15, 0, 0); chk(2, 6, 1, 1);
        drv(0, 0, 1, 4, 3);
        chk(2, 6, 0, 0);

        // 5: load clamp and priority over EN; LEN=0 and LEN>DEPTH
        test_no = 5; step_no = 0;
        drv(1, 0, 1, 7, 5);
        chk(4, 8, 0, 0);
        drv(1, 0, 0, 0, 0);
        chk(0, 15, 1, 1); chk(0, 15, 1, 2); chk(0, 15, 1, 3);
        drv(1, 1, 0, 0, 0);
        chk(0, 15, 1, 4);
        drv(1, 1, 0, 0, 7);
        chk(4, 8, 1, 5);
        drv(0, 1, 0, 0, 7);
        chk(4, 8, 0, 5);

        // 6: reset mid-run at WRAPS=200 restores defaults; WRAPS rollover
        test_no = 6; step_no = 0;
        drv(1, 0, 0, 0, 0);
        for (int w = 6; w <= 200; w++)
            chk(0, 15, 1, w);
        RESET = 1'b1;
        drv(1, 0, 1, 3, 5); wr(2, 1);
        chk(0, 2, 0, 0);
        RESET = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drv(0, 0, 1, k, 5);
            chk(k, 2 * (k + 1), 0, 0);
        end
        drv(0, 0, 1, 0, 5);
        chk(0, 2, 0, 0);
        drv(1, 0, 0, 0, 1);
        for (int i = 1; i <= 257; i++)
            chk(0, 2, 1, i % 256);
        drv(0, 0, 0, 0, 1);
        chk(0, 2, 0, 1);

        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
